// File: rtl/lsu_controller.sv
// Load/store sequencer: turns decoded memory intent from execute into a single
// word-aligned, byte-enabled request on the handshaked data-memory port, waits
// for the response, extracts/extends load data and stalls the pipeline meanwhile.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access outstanding; new op sampled and alignment-checked
// REQ     | memReq held high until memory accepts the request
// WAIT_RD | load accepted, waiting for memRvalid
// DONE    | one-cycle completion: accessDone (and loadValid for loads)
module lsu_controller #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [2:0]            sizeSrc,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           writeData,
    output logic                  stall,
    output logic [31:0]           readData,
    output logic                  loadValid,
    output logic                  accessDone,
    output logic                  misaligned,
    output logic                  timeoutErr,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memWdata,
    output logic [3:0]            memBe,
    input  logic                  memReady,
    input  logic                  memRvalid,
    input  logic [31:0]           memRdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;

    // Timeout fires on the edge that completes the TIMEOUT_CYCLES-th busy cycle.
    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        is_load;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [7:0]  tcnt;

    logic [2:0]  eff_size;
    logic        op_any;
    logic        mis;
    logic        start;
    logic        timeout_hit;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_val;

    // Effective access size: stores see only the width bits, loads fold undefined codes to signed byte.
    always_comb begin
        eff_size = 3'b000;
        if (memWrite) begin
            eff_size = {1'b0, (sizeSrc[1:0] == 2'b11) ? 2'b00 : sizeSrc[1:0]};
        end else begin
            case (sizeSrc)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: eff_size = sizeSrc;
                default:                                eff_size = 3'b000;
            endcase
        end
    end

    // Alignment check, request shaping and the combinational IDLE-cycle outputs.
    always_comb begin
        op_any = memRead | memWrite;
        mis    = ((eff_size[1:0] == 2'b01) && addr[0]) ||
                 ((eff_size[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        start       = (state == IDLE) && op_any && !mis;
        misaligned  = (state == IDLE) && op_any && mis;
        stall       = start || (state == REQ) || (state == WAIT_RD);
        timeout_hit = (tcnt >= TC_LAST);
        case (eff_size[1:0])
            2'b00: begin
                be_n = 4'b0001 << addr[1:0];
                wd_n = {4{writeData[7:0]}};
            end
            2'b01: begin
                be_n = 4'b0011 << addr[1:0];
                wd_n = {2{writeData[15:0]}};
            end
            default: begin
                be_n = 4'b1111;
                wd_n = writeData;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the returned word.
    always_comb begin
        byte_sel = memRdata[{off_q, 3'b000} +: 8];
        half_sel = memRdata[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            3'b000:  ld_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ld_val = {24'h0, byte_sel};
            3'b001:  ld_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  ld_val = {16'h0, half_sel};
            default: ld_val = memRdata;
        endcase
    end

    // Access sequencer with registered request signals and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_load    <= 1'b0;
            size_q     <= 3'b000;
            off_q      <= 2'b00;
            tcnt       <= 8'h00;
            readData   <= 32'h0;
            loadValid  <= 1'b0;
            accessDone <= 1'b0;
            timeoutErr <= 1'b0;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWdata   <= 32'h0;
            memBe      <= 4'h0;
        end else begin
            loadValid  <= 1'b0;
            accessDone <= 1'b0;
            timeoutErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= REQ;
                        is_load  <= !memWrite;
                        size_q   <= eff_size;
                        off_q    <= addr[1:0];
                        memAddr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        memBe    <= be_n;
                        memWdata <= wd_n;
                        memWe    <= memWrite;
                        memReq   <= 1'b1;
                        tcnt     <= 8'h00;
                    end
                end
                REQ: begin
                    tcnt <= tcnt + 8'h01;
                    if (memReady) begin
                        memReq <= 1'b0;
                        if (!is_load) begin
                            state      <= DONE;
                            accessDone <= 1'b1;
                        end else if (memRvalid) begin
                            state      <= DONE;
                            readData   <= ld_val;
                            loadValid  <= 1'b1;
                            accessDone <= 1'b1;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end else if (timeout_hit) begin
                        memReq     <= 1'b0;
                        state      <= DONE;
                        accessDone <= 1'b1;
                        timeoutErr <= 1'b1;
                        if (is_load) begin
                            readData  <= 32'h0;
                            loadValid <= 1'b1;
                        end
                    end
                end
                WAIT_RD: begin
                    tcnt <= tcnt + 8'h01;
                    if (memRvalid) begin
                        state      <= DONE;
                        readData   <= ld_val;
                        loadValid  <= 1'b1;
                        accessDone <= 1'b1;
                    end else if (timeout_hit) begin
                        state      <= DONE;
                        readData   <= 32'h0;
                        loadValid  <= 1'b1;
                        accessDone <= 1'b1;
                        timeoutErr <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: the driver pushes expected requests and
// completions computed by a size/offset arithmetic model, a randomized memory
// responder answers requests, and a monitor pops and compares on DUT outputs.
module tb_lsu_controller;

    localparam int TO = 8;

    logic        clk, rst_n;
    logic        memRead, memWrite;
    logic [2:0]  sizeSrc;
    logic [31:0] addr, writeData;
    logic        stall, loadValid, accessDone, misaligned, timeoutErr;
    logic [31:0] readData;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic [3:0]  memBe;
    logic        memReady, memRvalid;
    logic [31:0] memRdata;

    lsu_controller #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .sizeSrc(sizeSrc), .addr(addr), .writeData(writeData), .stall(stall),
        .readData(readData), .loadValid(loadValid), .accessDone(accessDone),
        .misaligned(misaligned), .timeoutErr(timeoutErr), .memReq(memReq),
        .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
        .memReady(memReady), .memRvalid(memRvalid), .memRdata(memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        logic        lv;
        logic        to;
        logic [31:0] rd;
        int          reqc;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    mis_cnt = 0;
    int    checks = 0;
    int    errors = 0;
    logic [31:0] model_rd = 32'h0;

    int          rdy_wait_cfg = 0;
    int          rv_wait_cfg = 0;
    logic [31:0] rdata_cfg = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic flag_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event seen but none expected", nm);
    endtask

    // Memory responder: accepts after rdy_wait_cfg cycles, returns data rv_wait_cfg cycles after acceptance.
    int rdy_cnt = -1;
    int rv_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rdy_cnt   = -1;
            rv_cnt    = 0;
            memReady  = 1'b0;
            memRvalid = 1'b0;
            memRdata  = 32'h0;
        end else begin
            memReady  = 1'b0;
            memRvalid = 1'b0;
            memRdata  = $urandom;
            if (memReq) begin
                if (rdy_cnt < 0) rdy_cnt = rdy_wait_cfg;
                if (rdy_cnt == 0) begin
                    memReady = 1'b1;
                    rdy_cnt  = -1;
                    if (!memWe) begin
                        if (rv_wait_cfg == 0) begin
                            memRvalid = 1'b1;
                            memRdata  = rdata_cfg;
                        end else begin
                            rv_cnt = rv_wait_cfg;
                        end
                    end
                end else begin
                    rdy_cnt--;
                end
            end else begin
                rdy_cnt  = -1;
                memReady = 1'($urandom_range(0, 1));
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        memRvalid = 1'b1;
                        memRdata  = rdata_cfg;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request, completion or rejection.
    logic prev_req = 1'b0;
    int   req_cycles = 0;
    always @(negedge clk) begin
        req_t  r;
        done_t d;
        if (!rst_n) begin
            prev_req   = 1'b0;
            req_cycles = 0;
        end else begin
            if (memReq) begin
                req_cycles++;
                chk("stall_in_req", 32'(stall), 32'd1);
                if (!prev_req) begin
                    if (req_q.size() == 0) flag_fail("unexpected_req");
                    else begin
                        r = req_q.pop_front();
                        chk("memWe", 32'(memWe), 32'(r.we));
                        chk("memAddr", memAddr, r.a);
                        chk("memBe", 32'(memBe), 32'(r.be));
                        if (r.we) chk("memWdata", memWdata, r.wd);
                    end
                end
            end
            prev_req = memReq;
            if (accessDone) begin
                if (done_q.size() == 0) flag_fail("unexpected_done");
                else begin
                    d = done_q.pop_front();
                    chk("loadValid", 32'(loadValid), 32'(d.lv));
                    chk("timeoutErr", 32'(timeoutErr), 32'(d.to));
                    chk("readData", readData, d.rd);
                    chk("stall_in_done", 32'(stall), 32'd0);
                    chk("req_cycles", 32'(req_cycles), 32'(d.reqc));
                end
                req_cycles = 0;
            end
            if (loadValid && !accessDone) flag_fail("loadValid_alone");
            if (timeoutErr && !accessDone) flag_fail("timeoutErr_alone");
            if (misaligned) begin
                if (mis_cnt == 0) flag_fail("unexpected_misaligned");
                else begin
                    mis_cnt--;
                    chk("mis_memReq", 32'(memReq), 32'd0);
                    chk("mis_stall", 32'(stall), 32'd0);
                end
            end
        end
    end

    // Reference model plus drive of one operation; waits for completion when one is expected.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int rdyw, input int rvw, input logic [31:0] rdat);
        int n, off;
        bit sgn, mis, timed_out, got;
        logic [31:0] mask, val;
        req_t  r;
        done_t d;
        if (!rd && !wr) begin
            @(posedge clk); #1;
            memRead = 1'b0; memWrite = 1'b0;
            return;
        end
        sgn = 1'b0;
        if (wr) begin
            case (sz[1:0])
                2'b01:   n = 2;
                2'b10:   n = 4;
                default: n = 1;
            endcase
        end else begin
            case (sz)
                3'b001:  begin n = 2; sgn = 1'b1; end
                3'b010:  n = 4;
                3'b100:  n = 1;
                3'b101:  n = 2;
                default: begin n = 1; sgn = 1'b1; end
            endcase
        end
        off = int'(a[1:0]);
        mis = (off % n) != 0;
        if (mis) mis_cnt++;
        else begin
            r.we = wr;
            r.a  = a & ~32'h3;
            r.be = 4'(((1 << n) - 1) << off);
            r.wd = (n == 1) ? (wd & 32'hFF) * 32'h01010101 :
                   (n == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
            req_q.push_back(r);
            timed_out = rdyw >= TO;
            if (!wr) begin
                if (timed_out) val = 32'h0;
                else begin
                    mask = (n == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * n)) - 32'd1);
                    val  = (rdat >> (8 * off)) & mask;
                    if (sgn && val[8 * n - 1]) val = val | ~mask;
                end
                model_rd = val;
            end
            d.lv = !wr; d.to = timed_out; d.rd = model_rd;
            d.reqc = timed_out ? TO : rdyw + 1;
            done_q.push_back(d);
        end
        rdy_wait_cfg = rdyw; rv_wait_cfg = rvw; rdata_cfg = rdat;
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; sizeSrc = sz; addr = a; writeData = wd;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'(!mis));
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0; addr = $urandom; writeData = $urandom;
        if (!mis) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (accessDone) got = 1'b1;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL done_wait: got no accessDone expected one within 40 cycles");
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; sizeSrc = 3'b000;
        addr = 32'h0; writeData = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_readData", readData, 32'h0);
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_memWe", 32'(memWe), 32'd0);
        chk("rst_memBe", 32'(memBe), 32'd0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_memWdata", memWdata, 32'h0);
        chk("rst_pulses", {28'h0, accessDone, loadValid, timeoutErr, misaligned}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        issue(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0);
        issue(1, 0, 3'b000, 32'h203, 32'h0, 0, 2, 32'h80112233);
        issue(1, 0, 3'b100, 32'h203, 32'h0, 0, 2, 32'h80112233);
        issue(1, 0, 3'b001, 32'h202, 32'h0, 0, 0, 32'h80011234);
        issue(1, 0, 3'b101, 32'h202, 32'h0, 0, 0, 32'h80011234);
        issue(0, 1, 3'b000, 32'h101, 32'h000000A5, 1, 0, 32'h0);
        issue(0, 1, 3'b001, 32'h201, 32'h0000BEEF, 0, 0, 32'h0);
        issue(1, 0, 3'b010, 32'h300, 32'h0, 1000, 0, 32'hCAFEF00D);

        // Reset while a load sits in WAIT_RD: no completion may follow.
        rdy_wait_cfg = 0; rv_wait_cfg = 6; rdata_cfg = 32'h55AA55AA;
        req_q.push_back('{1'b0, 32'h400, 4'hF, 32'h0});
        @(posedge clk); #1;
        memRead = 1'b1; sizeSrc = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        memRead = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_memReq", 32'(memReq), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_pulses", {30'h0, accessDone, loadValid}, 32'h0);
        chk("rst_mid_readData", readData, 32'h0);
        req_q.delete(); done_q.delete(); model_rd = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(1, 0, 3'b010, 32'h0, 32'h0, 0, 1, 32'h12345678);

        for (int k = 0; k < 40; k++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'h1000 + 32'($urandom_range(0, 255)), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        repeat (4) @(negedge clk);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        chk("mis_drained", 32'(mis_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
